// File: rtl/periph_bridge.sv
// periph_bridge: core data port to an N-slot peripheral bus, one access at a time.
// Define PERIPH_TIMEOUT_EN to build the stuck-slave timeout.
package periph_bridge_pkg;
  typedef enum logic [2:0] {
    MEM_STORE_NONE   = 3'd0,
    MEM_STORE_BYTE   = 3'd1,
    MEM_STORE_HALF   = 3'd2,
    MEM_STORE_WORD   = 3'd3,
    MEM_STORE_DOUBLE = 3'd4
  } mem_store_type_t;
endpackage

module periph_bridge
  import periph_bridge_pkg::*;
#(
  parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
  parameter int N_SLOTS        = 4,
  parameter int SLOT_SHIFT     = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [63:0]             d_addr,
  input  logic [63:0]             d_wdata,
  input  mem_store_type_t         d_store_type,
  input  logic                    d_valid,
  output logic [63:0]             d_rdata,
  output logic                    d_ready,
  output logic [N_SLOTS-1:0]      p_sel,
  output logic [SLOT_SHIFT-1:0]   p_addr,
  output logic [63:0]             p_wdata,
  output mem_store_type_t         p_store_type,
  input  logic [64*N_SLOTS-1:0]   p_rdata,
  input  logic [N_SLOTS-1:0]      p_ready,
  output logic                    bus_error
);

  localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]            state;
  logic [SLOT_W-1:0]     slot_q;
  logic [SLOT_SHIFT-1:0] addr_q;
  logic [63:0]           wdata_q;
  logic [63:0]           resp_q;
  mem_store_type_t       st_q;
  logic                  err_q;

  logic [63:0] offset;
  logic [63:0] slot_idx;
  logic        unmapped;
  logic        in_access;
  logic        hit;
  logic        expired;
  logic [63:0] slice;
  int          sidx;

  assign offset    = d_addr - PERIPHERAL_BASE;
  assign slot_idx  = offset >> SLOT_SHIFT;
  // below-base addresses wrap in offset, so check them explicitly
  assign unmapped  = (d_addr < PERIPHERAL_BASE)
                   || (slot_idx >= 64'(N_SLOTS));
  assign in_access = (state == ACCESS);
  assign sidx      = int'(slot_q);
  assign hit       = p_ready[slot_q];
  assign slice     = p_rdata[sidx*64 +: 64];

`ifdef PERIPH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  assign expired = !hit
                 && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (!in_access) begin
      cnt <= '0;
    end else if (!hit) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      slot_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      st_q    <= MEM_STORE_NONE;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_valid) begin
            slot_q  <= slot_idx[SLOT_W-1:0];
            addr_q  <= offset[SLOT_SHIFT-1:0];
            wdata_q <= d_wdata;
            st_q    <= d_store_type;
            err_q   <= unmapped;
            resp_q  <= '0;
            state   <= unmapped ? DONE : ACCESS;
          end
        end
        ACCESS: begin
          if (hit) begin
            resp_q <= (st_q == MEM_STORE_NONE) ? slice : '0;
            state  <= DONE;
          end else if (expired) begin
            resp_q <= '0;
            err_q  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          resp_q <= '0;
          err_q  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    p_sel = '0;
    if (in_access) p_sel[slot_q] = 1'b1;
  end

  assign p_addr       = in_access ? addr_q : '0;
  assign p_wdata      = in_access ? wdata_q : '0;
  assign p_store_type = in_access ? st_q : MEM_STORE_NONE;

  assign d_ready   = (state == DONE);
  assign d_rdata   = d_ready ? resp_q : '0;
  assign bus_error = d_ready && err_q;

endmodule

// File: tb/tb_periph_bridge.sv
// tb_periph_bridge: directed bench with a cycle-schedule model of the bridge.
// Timeout tests build only when PERIPH_TIMEOUT_EN is defined.
module tb_periph_bridge;
  import periph_bridge_pkg::*;

  localparam logic [63:0] BASE = 64'h2000_0000;
  localparam int NS   = 4;
  localparam int SH   = 12;
  localparam int TO   = 8;
  localparam int MAXC = 1024;
`ifdef PERIPH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic [63:0]     d_addr;
  logic [63:0]     d_wdata;
  mem_store_type_t d_store_type;
  logic            d_valid;
  logic [63:0]     d_rdata;
  logic            d_ready;
  logic [NS-1:0]   p_sel;
  logic [SH-1:0]   p_addr;
  logic [63:0]     p_wdata;
  mem_store_type_t p_store_type;
  logic [64*NS-1:0] p_rdata;
  logic [NS-1:0]   p_ready;
  logic            bus_error;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  logic [63:0]     slot_data [NS];
  logic [NS-1:0]   e_sel   [MAXC];
  bit              e_rdy   [MAXC];
  bit              e_err   [MAXC];
  logic [63:0]     e_rd    [MAXC];
  logic [SH-1:0]   e_pa    [MAXC];
  logic [63:0]     e_pw    [MAXC];
  mem_store_type_t e_st    [MAXC];
  logic [NS-1:0]   r_sched [MAXC];

  periph_bridge #(
    .PERIPHERAL_BASE(BASE),
    .N_SLOTS(NS),
    .SLOT_SHIFT(SH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_store_type(d_store_type),
    .d_valid(d_valid),
    .d_rdata(d_rdata),
    .d_ready(d_ready),
    .p_sel(p_sel),
    .p_addr(p_addr),
    .p_wdata(p_wdata),
    .p_store_type(p_store_type),
    .p_rdata(p_rdata),
    .p_ready(p_ready),
    .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("p_sel", 64'(p_sel), 64'(e_sel[cyc]));
      chk("d_ready", 64'(d_ready), 64'(e_rdy[cyc]));
      chk("bus_error", 64'(bus_error), 64'(e_err[cyc]));
      if (e_rdy[cyc]) chk("d_rdata", d_rdata, e_rd[cyc]);
      if (e_sel[cyc] != '0) begin
        chk("p_addr", 64'(p_addr), 64'(e_pa[cyc]));
        chk("p_wdata", p_wdata, e_pw[cyc]);
        chk("p_store_type", 64'(p_store_type), 64'(e_st[cyc]));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    p_ready = r_sched[cyc];
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clear(input int a, input int b);
    for (int k = a; k <= b; k++) begin
      e_sel[k] = '0;
      e_rdy[k] = 1'b0;
      e_err[k] = 1'b0;
      e_rd[k] = '0;
      r_sched[k] = '0;
    end
  endtask

  // Present a request in the current cycle and schedule what the bridge
  // must show: p_sel from the next cycle for (wait+1) cycles, then d_ready.
  task automatic present(input logic [63:0] a,
                         input logic [63:0] wd,
                         input mem_store_type_t st,
                         input int wt,
                         output int done);
    int c, s, n;
    bit stuck;
    logic [63:0] off, six;
    logic [NS-1:0] bs, noise;
    c = cyc;
    off = a - BASE;
    six = off >> SH;
    if (a < BASE || six >= 64'(NS)) begin
      done = c + 1;
      e_rdy[done] = 1'b1;
      e_err[done] = 1'b1;
      e_rd[done] = '0;
    end else begin
      s = int'(six);
      bs = NS'(1) << s;
      noise = NS'(1) << ((s + 1) % NS);
      stuck = TO_EN && (wt < 0 || wt >= TO);
      n = stuck ? TO : wt + 1;
      for (int k = 0; k < n; k++) begin
        e_sel[c+1+k] = bs;
        e_pa[c+1+k] = off[SH-1:0];
        e_pw[c+1+k] = wd;
        e_st[c+1+k] = st;
        r_sched[c+1+k] = r_sched[c+1+k] | noise;
      end
      if (!stuck) r_sched[c+1+wt] = r_sched[c+1+wt] | bs;
      done = c + 1 + n;
      e_rdy[done] = 1'b1;
      e_err[done] = stuck;
      e_rd[done] = (stuck || st != MEM_STORE_NONE) ? 64'h0 : slot_data[s];
    end
    d_valid = 1'b1;
    d_addr = a;
    d_wdata = wd;
    d_store_type = st;
  endtask

  initial begin
    int c0, done, done1, done2;
    slot_data[0] = 64'hA5A5_0000_DEAD_0000;
    slot_data[1] = 64'h0000_0000_0000_1234;
    slot_data[2] = 64'hC0FF_EE00_0000_0002;
    slot_data[3] = 64'hFEED_FACE_CAFE_BEEF;
    for (int i = 0; i < NS; i++) p_rdata[64*i +: 64] = slot_data[i];
    for (int k = 0; k < MAXC; k++) begin
      e_sel[k] = '0;
      e_rdy[k] = 1'b0;
      e_err[k] = 1'b0;
      e_rd[k] = '0;
      e_pa[k] = '0;
      e_pw[k] = '0;
      e_st[k] = MEM_STORE_NONE;
      r_sched[k] = '0;
    end
    reset = 1'b1;
    d_valid = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    d_store_type = MEM_STORE_NONE;
    p_ready = '0;
    tick();
    tick();
    chk("rst_d_ready", 64'(d_ready), 64'h0);
    chk("rst_d_rdata", d_rdata, 64'h0);
    chk("rst_p_sel", 64'(p_sel), 64'h0);
    chk("rst_p_addr", 64'(p_addr), 64'h0);
    chk("rst_p_wdata", p_wdata, 64'h0);
    chk("rst_p_st", 64'(p_store_type), 64'h0);
    chk("rst_bus_error", 64'(bus_error), 64'h0);
    reset = 1'b0;
    chk_en = 1'b1;
    tick();

    // read slot 1, slave ready at once
    present(64'h2000_1008, 64'h0, MEM_STORE_NONE, 0, done);
    tick();
    d_valid = 1'b0;
    chk("t1_psel", 64'(p_sel), 64'h2);
    chk("t1_paddr", 64'(p_addr), 64'h008);
    tick();
    chk("t1_dready", 64'(d_ready), 64'h1);
    chk("t1_rdata", d_rdata, 64'h1234);
    chk("t1_berr", 64'(bus_error), 64'h0);
    run_to(done + 1);

    // write slot 3, three wait cycles, unselected p_ready noise
    c0 = cyc;
    present(64'h2000_3010, 64'hAB, MEM_STORE_WORD, 3, done);
    tick();
    d_valid = 1'b0;
    chk("t2_psel", 64'(p_sel), 64'h8);
    chk("t2_pwdata", p_wdata, 64'hAB);
    run_to(c0 + 4);
    chk("t2_psel_hold", 64'(p_sel), 64'h8);
    chk("t2_no_ready", 64'(d_ready), 64'h0);
    run_to(c0 + 5);
    chk("t2_dready", 64'(d_ready), 64'h1);
    chk("t2_rdata", d_rdata, 64'h0);
    run_to(done + 1);

    // unmapped above the last window
    present(64'h2000_5000, 64'h55, MEM_STORE_BYTE, 0, done);
    tick();
    d_valid = 1'b0;
    chk("t3_dready", 64'(d_ready), 64'h1);
    chk("t3_berr", 64'(bus_error), 64'h1);
    chk("t3_rdata", d_rdata, 64'h0);
    chk("t3_psel", 64'(p_sel), 64'h0);
    run_to(done + 1);

    // below base, first unmapped window, last mapped byte
    present(64'h1FFF_FFF8, 64'h0, MEM_STORE_NONE, 0, done);
    tick();
    d_valid = 1'b0;
    run_to(done + 1);
    present(64'h2000_4000, 64'h0, MEM_STORE_NONE, 0, done);
    tick();
    d_valid = 1'b0;
    run_to(done + 1);
    present(64'h2000_3FFF, 64'h77, MEM_STORE_NONE, 2, done);
    tick();
    d_valid = 1'b0;
    run_to(done + 1);

    // d_valid held through two requests: slot 0 then slot 2
    present(64'h2000_0100, 64'h0, MEM_STORE_NONE, 1, done1);
    run_to(done1 + 1);
    present(64'h2000_2018, 64'h0, MEM_STORE_NONE, 0, done2);
    tick();
    d_valid = 1'b0;
    chk("t5_gap", 64'(cyc - done1), 64'd2);
    chk("t5_psel2", 64'(p_sel), 64'h4);
    run_to(done2 + 1);

    // reset in the middle of an access, then a clean access
    c0 = cyc;
    present(64'h2000_2000, 64'h99, MEM_STORE_DOUBLE, 6, done);
    tick();
    d_valid = 1'b0;
    tick();
    reset = 1'b1;
    clear(c0 + 3, c0 + 40);
    tick();
    chk("t6_psel", 64'(p_sel), 64'h0);
    chk("t6_dready", 64'(d_ready), 64'h0);
    reset = 1'b0;
    present(64'h2000_0008, 64'h0, MEM_STORE_NONE, 1, done);
    tick();
    d_valid = 1'b0;
    run_to(done);
    chk("t6_rdata", d_rdata, 64'hA5A5_0000_DEAD_0000);
    run_to(done + 1);

`ifdef PERIPH_TIMEOUT_EN
    // slave never ready: timeout error after TO cycles of p_sel
    c0 = cyc;
    present(64'h2000_1000, 64'h0, MEM_STORE_NONE, -1, done);
    tick();
    d_valid = 1'b0;
    run_to(c0 + 9);
    chk("t7_to_dready", 64'(d_ready), 64'h1);
    chk("t7_to_berr", 64'(bus_error), 64'h1);
    run_to(done + 1);
    // ready on the last allowed cycle wins
    c0 = cyc;
    present(64'h2000_1000, 64'h0, MEM_STORE_NONE, 7, done);
    tick();
    d_valid = 1'b0;
    run_to(c0 + 9);
    chk("t7_late_berr", 64'(bus_error), 64'h0);
    chk("t7_late_rdata", d_rdata, 64'h1234);
    run_to(done + 1);
`else
    // without the timeout a slow slave just completes
    c0 = cyc;
    present(64'h2000_1000, 64'h0, MEM_STORE_NONE, 12, done);
    tick();
    d_valid = 1'b0;
    run_to(c0 + 14);
    chk("t7_slow_dready", 64'(d_ready), 64'h1);
    chk("t7_slow_berr", 64'(bus_error), 64'h0);
    run_to(done + 1);
`endif

    tick();
    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_bridge.md
# periph_bridge

Data-side peripheral bridge sitting directly downstream of the core's peripheral data port. It accepts one core request per valid/ready handshake, decodes the address into one of `N_SLOTS` peripheral windows above `PERIPHERAL_BASE`, and drives a shared slave bus with a per-slot select. It waits for the selected slave's ready, then returns read data and a one-cycle `d_ready` that releases the core's stall. Unmapped or stuck accesses complete with an error pulse.

## Interface
- `PERIPHERAL_BASE`, default 64'h2000_0000: base of the peripheral region; matches the core's parameter.
- `N_SLOTS`, default 4: number of peripheral windows (1..16).
- `SLOT_SHIFT`, default 12: log2 of the window size; slot index = (`d_addr` − `PERIPHERAL_BASE`) >> `SLOT_SHIFT`.
- `TIMEOUT_CYCLES`, default 255: maximum ACCESS cycles; used only with `PERIPH_TIMEOUT_EN`.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `d_addr`  in  64  core request address.
- `d_wdata`  in  64  core store data.
- `d_store_type`  in  mem_store_type_t  nonzero = write, zero = read.
- `d_valid`  in  1  core request pending.
- `d_rdata`  out  64  read data, valid while `d_ready`=1.
- `d_ready`  out  1  one-cycle completion pulse.
- `p_sel`  out  N_SLOTS  one-hot slave select.
- `p_addr`  out  SLOT_SHIFT  in-window offset.
- `p_wdata`  out  64  store data.
- `p_store_type`  out  mem_store_type_t  store type; zero on reads.
- `p_rdata`  in  64*N_SLOTS  slave read data; slot i occupies bits [64i+63:64i].
- `p_ready`  in  N_SLOTS  slave done, per slot.
- `bus_error`  out  1  one-cycle pulse on an unmapped or timed-out access; intended for an `interrupt_sources` bit.

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE**
  - If `d_valid`=1, latch the address, wdata, store type and decoded slot.
  - If `d_addr` < `PERIPHERAL_BASE` or slot ≥ `N_SLOTS`: go to DONE with the error flag set. No `p_sel` is ever driven.
  - Otherwise go to ACCESS.
- **ACCESS**
  - `p_sel[slot]`=1, and `p_addr`/`p_wdata`/`p_store_type` come from the latched values. These stay stable for the whole state.
  - On `p_ready[slot]`=1: capture `p_rdata` slice `slot` into the response register (zero for writes), then go to DONE.
  - `p_ready` bits of unselected slots are ignored.
- **DONE**
  - `d_ready`=1 and `d_rdata`=response register.
  - Error case: `d_rdata`=0 and `bus_error`=1 in this cycle.
  - Always return to IDLE.
- Requests are never aborted. If `d_valid` drops during ACCESS (core flush), the slave access still completes and the `d_ready` pulse is still issued, then ignored by the core.
- The next request is sampled only in IDLE. A `d_valid` held high through DONE is treated as a new request of the next instruction, because the core advances on the DONE edge.
- `reset` mid-access returns to IDLE and drops `p_sel` immediately. A slave mid-transaction is abandoned.
- Reset values: state=IDLE; `d_ready`=0, `d_rdata`=0, `p_sel`=0, `p_addr`=0, `p_wdata`=0, `p_store_type`=0, `bus_error`=0; timeout counter=0.

## Timing
- All outputs are registered or decoded from the registered state; there are no combinational paths from `d_*` inputs to `p_*` outputs.
- Mapped access with the slave ready in its first ACCESS cycle:
  - `d_valid` first seen at edge 0;
  - `p_sel` high in cycle 1;
  - `d_ready` high in cycle 2.
  - Total: 2-cycle latency, plus one cycle per slave wait cycle.
- Unmapped access: `d_ready` and `bus_error` in cycle 1.
- Back-to-back requests: DONE → IDLE → ACCESS, so throughput is one access per 3 cycles minimum.
- Counter: 8 bits wide by default (width = clog2(`TIMEOUT_CYCLES`+1)). It clears on entry to ACCESS and increments each ACCESS cycle without `p_ready`.

## Configuration
- `PERIPH_TIMEOUT_EN` defined:
  - If the counter reaches `TIMEOUT_CYCLES` in ACCESS without `p_ready`, drop `p_sel` and go to DONE with the error flag: `d_rdata`=0 and `bus_error`=1.
  - `p_ready` arriving in that same cycle wins: normal completion, no error.
- `PERIPH_TIMEOUT_EN` undefined:
  - The counter is not built, and ACCESS waits indefinitely.
  - `bus_error` is raised only for unmapped accesses.

## Test plan
- Read slot 1 at 0x2000_1008, slave 1 `p_ready` immediate, `p_rdata` slice=0x1234 -> `p_sel`=4'b0010 and `p_addr`=0x008 in cycle 1; `d_ready`=1 with `d_rdata`=0x1234 in cycle 2; `bus_error`=0.
- Write to 0x2000_3010 with `d_wdata`=0xAB and slave 3 ready after 3 wait cycles -> `p_sel`=4'b1000 and `p_wdata`=0xAB held for 4 cycles; `d_ready` in cycle 5 with `d_rdata`=0.
- Unmapped access to 0x2000_5000 (`N_SLOTS`=4) -> `d_ready`=1 and `bus_error`=1 in cycle 1, `d_rdata`=0, `p_sel` never asserted.
- `PERIPH_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, slave never ready -> `p_sel` held 8 cycles, then `d_ready`+`bus_error`; repeat with `p_ready` on the 8th cycle -> normal completion, no error.
- `d_valid` held high across two consecutive requests (slots 0 then 2) -> two distinct accesses, with the second `p_sel` asserted 2 cycles after the first `d_ready`.
- `reset` asserted during ACCESS -> next cycle `p_sel`=0, `d_ready`=0, state IDLE; a new request afterwards completes normally.
